pos_ram_access_ctrl: RTL and testbench
======================================

Name: pos_ram_access_ctrl

Overview:
- Sequences and shares one single-port position RAM bank (32-bit words, 2-cycle registered read) between two clients.
- Client 1 is a burst reader: the force-pipeline particle fetch. It streams `rd_count` consecutive words from `rd_base` out through a ready/valid port with backpressure.
- Client 2 is a single-word writer: the motion-update position write-back, using a valid/ready handshake.
- The block sits directly in front of each position RAM instance. It owns all RAM control pins.

Parameters:
- DEPTH, 512, RAM words; address wraps modulo DEPTH.
- ADDR_WIDTH, 9, RAM address width; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, word width.
- BUF_DEPTH, 4, read-return buffer entries; also the read credit limit.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_start  in  1  burst request pulse; sampled only in IDLE.
- rd_base  in  ADDR_WIDTH  first burst address.
- rd_count  in  ADDR_WIDTH+1  words in burst, 0..DEPTH.
- rd_busy  out  1  high whenever the state is not IDLE.
- rd_done  out  1  one-cycle pulse at burst completion.
- out_data  out  DATA_WIDTH  burst word at buffer head.
- out_valid  out  1  buffer not empty.
- out_last  out  1  head word is the final word of the burst.
- out_ready  in  1  consumer accepts head word.
- wr_valid  in  1  write request.
- wr_ready  out  1  write granted this cycle (combinational).
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- ram_address  out  ADDR_WIDTH  to RAM address.
- ram_data  out  DATA_WIDTH  to RAM data.
- ram_rden  out  1  to RAM rden.
- ram_wren  out  1  to RAM wren.
- ram_q  in  DATA_WIDTH  from RAM q; valid 2 cycles after ram_rden.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - state = IDLE; all counters = 0; buffer empty; read-valid pipe cleared; last_grant = READ.
  - rd_busy, rd_done, out_valid, out_last, wr_ready, ram_rden and ram_wren are all 0. out_data and ram_address are 0.
- Reset mid-burst discards everything in flight. No rd_done is produced for the aborted burst.
- States:
  - IDLE:
    - rd_start with rd_count != 0: latch base and count, clear issued/returned counters, go to ISSUE.
    - rd_start with rd_count == 0: go to DONE.
  - ISSUE: issue reads; go to DRAIN once issued == count.
  - DRAIN: go to DONE in the cycle after the handshake of the out_last word.
  - DONE: rd_done = 1 for exactly one cycle, then IDLE.
- rd_start outside IDLE is ignored.
- Slot rule: exactly one RAM operation per cycle at most; ram_rden and ram_wren are never both high.
- Read candidate conditions (all required):
  - state == ISSUE;
  - issued < count;
  - (reads in flight + buffer occupancy) < BUF_DEPTH.
- Write candidate: wr_valid. Writes are accepted in every state.
- Arbitration:
  - Only one candidate: it wins.
  - Both candidates: grant the client that did not win the previous conflict, then update last_grant. Non-conflict cycles do not update last_grant.
  - Consequence: the first conflict after reset goes to WRITE.
- RAM drive is combinational from the grant:
  - Write grant: wr_ready = 1, ram_wren = 1, ram_address = wr_addr, ram_data = wr_data.
  - Read grant: ram_rden = 1, ram_address = (base + issued) mod DEPTH; issued increments.
  - ram_data is don't-care on reads; drive it as wr_data.
- Read return timing:
  - A read issued in cycle N has ram_q captured at the end of N+2.
  - out_valid is visible in cycle N+3.
  - With out_ready held high and no writes, throughput is 1 word per cycle.
- Tag the return with last when its sequence index == count-1.
- Buffer:
  - FIFO, first-word-fall-through.
  - A pop occurs on out_valid & out_ready.
  - A push and a pop in the same cycle are both performed.
  - Overflow is impossible by credit.
- Ordering: data reflects RAM contents in the issue cycle. A write granted after a read issue does not alter that read's returned word.
- Address wrap: DEPTH-1 is followed by 0. count == DEPTH reads every word exactly once.

Test Plan:
- Burst read, base=0, count=8, out_ready=1, no writes, RAM[i]=i -> ram_rden high for 8 consecutive cycles with ram_address 0..7. First out_valid 3 cycles after the first rden. Data 0..7 in order; out_last on word 7. rd_done pulses the cycle after that handshake; rd_busy falls the following cycle.
- Wrap, base=510, count=4 -> ram_address 510, 511, 0, 1; out_last on the 4th word only.
- Backpressure, count=10, out_ready=0 -> exactly 4 rden issued, then the issue stalls with out_valid=1. Release out_ready -> the remaining 6 are issued and all 10 words are delivered in order, with none lost or duplicated.
- Contention: wr_valid held high across a count=4 burst -> grants run W, R, W, R, ...; wr_ready and ram_rden alternate. After each write, RAM holds wr_data.
- Zero-length: rd_start with rd_count=0 -> no ram_rden, no out_valid; rd_done high in the cycle after rd_start; rd_busy high for that one cycle.
- Reset mid-burst after 3 of 8 words -> all outputs 0 and the buffer empty immediately. A new burst (base=100, count=2) then returns RAM[100] and RAM[101] only.

Source files
------------

// File: rtl/pos_ram_access_ctrl.sv
// pos_ram_access_ctrl: shares one single-port position RAM between a burst reader and a single-word writer
// Ports: clock/rst_n (async active-low); rd_start/rd_base/rd_count start a burst, rd_busy/rd_done report it;
// out_data/out_valid/out_last/out_ready stream burst words from a FWFT buffer; wr_valid/wr_ready/wr_addr/wr_data
// request a write; ram_address/ram_data/ram_rden/ram_wren drive the RAM, ram_q returns data 2 cycles after rden.
module pos_ram_access_ctrl #(
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  rd_start,
  input  logic [ADDR_WIDTH-1:0] rd_base,
  input  logic [ADDR_WIDTH:0]   rd_count,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_rden,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
);
  localparam int BW = $clog2(BUF_DEPTH);
  localparam logic [BW+1:0] BUF_LIM = (BW+2)'(BUF_DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0] count_q, count_d, issued_q, issued_d, ret_q, ret_d, sum;
  logic p0_q, p1_q, last_wr_q, last_wr_d;
  logic [DATA_WIDTH:0] buf_q [BUF_DEPTH];
  logic [BW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [BW:0] occ_q, occ_d;
  logic [BW+1:0] used;
  logic wr_cand, rd_cand, grant_wr, grant_rd, push, pop;
  always_comb begin
    // credit: words in the RAM pipe plus words already buffered must fit the buffer
    used = (BW+2)'(occ_q) + (BW+2)'(p0_q) + (BW+2)'(p1_q);
    rd_cand = state_q == ISSUE && issued_q < count_q && used < BUF_LIM;
    wr_cand = wr_valid && rst_n;
    // on conflict the client that lost the previous conflict wins
    grant_wr = wr_cand && (!rd_cand || !last_wr_q);
    grant_rd = rd_cand && !grant_wr;
    last_wr_d = rd_cand && wr_cand ? grant_wr : last_wr_q;
    sum = {1'b0, base_q} + issued_q;
    ram_address = grant_wr ? wr_addr : grant_rd ? ADDR_WIDTH'(sum >= DEPTH_W ? sum - DEPTH_W : sum) : '0;
    ram_data = wr_data;
    ram_wren = grant_wr;
    ram_rden = grant_rd;
    wr_ready = grant_wr;
    out_valid = occ_q != '0;
    out_data = buf_q[rp_q][DATA_WIDTH-1:0];
    out_last = out_valid && buf_q[rp_q][DATA_WIDTH];
    rd_busy = state_q != IDLE;
    rd_done = state_q == DONE;
    push = p1_q;
    pop = out_valid && out_ready;
    wp_d = wp_q + BW'(push);
    rp_d = rp_q + BW'(pop);
    occ_d = occ_q + (BW+1)'(push) - (BW+1)'(pop);
    issued_d = issued_q + (ADDR_WIDTH+1)'(grant_rd);
    ret_d = ret_q + (ADDR_WIDTH+1)'(push);
    base_d = base_q;
    count_d = count_q;
    state_d = state_q;
    case (state_q)
      IDLE: if (rd_start) begin
        base_d = rd_base;
        count_d = rd_count;
        issued_d = '0;
        ret_d = '0;
        state_d = rd_count == '0 ? DONE : ISSUE;
      end
      ISSUE: state_d = issued_q == count_q ? DRAIN : ISSUE;
      DRAIN: state_d = pop && out_last ? DONE : DRAIN;
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q <= '0;
      count_q <= '0;
      issued_q <= '0;
      ret_q <= '0;
      p0_q <= 1'b0;
      p1_q <= 1'b0;
      last_wr_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      count_q <= count_d;
      issued_q <= issued_d;
      ret_q <= ret_d;
      p0_q <= grant_rd;
      p1_q <= p0_q;
      last_wr_q <= last_wr_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      occ_q <= occ_d;
      if (push) buf_q[wp_q] <= {ret_q == count_q - (ADDR_WIDTH+1)'(1), ram_q};
    end
  end
endmodule

// File: tb/tb_pos_ram_access_ctrl.sv
// tb_pos_ram_access_ctrl: directed and randomized checks of pos_ram_access_ctrl against a shadow-memory model
module tb_pos_ram_access_ctrl;
  logic clock, rst_n, rd_start, rd_busy, rd_done, out_valid, out_last, out_ready;
  logic wr_valid, wr_ready, ram_rden, ram_wren;
  logic [8:0] rd_base, wr_addr, ram_address;
  logic [9:0] rd_count;
  logic [31:0] out_data, wr_data, ram_data, ram_q, r1;
  logic [31:0] mem [512];
  logic [31:0] shadow [512];
  logic [31:0] exp_q [$];
  bit ld;
  int checks, failures;
  int m_base, m_count, m_iss, m_pop, n_rden, n_last;
  pos_ram_access_ctrl dut (
    .clock(clock), .rst_n(rst_n), .rd_start(rd_start), .rd_base(rd_base), .rd_count(rd_count),
    .rd_busy(rd_busy), .rd_done(rd_done), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .ram_address(ram_address), .ram_data(ram_data),
    .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_q(ram_q)
  );
  initial clock = 0;
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (ld) for (int i = 0; i < 512; i++) mem[i] <= 32'(i);
    else if (ram_wren) mem[ram_address] <= ram_data;
    if (ram_rden) r1 <= mem[ram_address];
    ram_q <= r1;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clock) begin
    int a;
    if (ld) for (int i = 0; i < 512; i++) shadow[i] = 32'(i);
    if (!rst_n) exp_q.delete();
    else begin
      chk("slot_rule", 64'(ram_rden & ram_wren), 0);
      chk("wr_ready_eq_wren", 64'(wr_ready), 64'(ram_wren));
      if (ram_rden) begin
        a = (m_base + m_iss) % 512;
        chk("rd_addr", 64'(ram_address), 64'(a));
        chk("rd_in_range", 64'(m_iss < m_count), 1);
        exp_q.push_back(shadow[a]);
        m_iss++;
        n_rden++;
      end
      if (ram_wren) begin
        chk("wr_valid_on_grant", 64'(wr_valid), 1);
        chk("wr_addr", 64'(ram_address), 64'(wr_addr));
        chk("wr_data", 64'(ram_data), 64'(wr_data));
        shadow[wr_addr] = wr_data;
      end
      if (out_valid && out_ready) begin
        chk("word_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
        chk("out_last", 64'(out_last), 64'(m_pop == m_count - 1));
        m_pop++;
        if (out_last) n_last++;
      end
    end
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic start(input int b, input int c);
    rd_base = 9'(b);
    rd_count = 10'(c);
    rd_start = 1;
    m_base = b;
    m_count = c;
    m_iss = 0;
    m_pop = 0;
    n_rden = 0;
    n_last = 0;
  endtask
  task automatic finish(input string tag, input int c, input bit rnd);
    bit done;
    done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      tick();
      rd_start = 0;
      if (rnd) begin
        out_ready = 1'($urandom_range(0, 3) != 0);
        wr_valid = 1'($urandom_range(0, 2) == 0);
        wr_addr = 9'($urandom);
        wr_data = $urandom;
      end
      @(negedge clock);
      done = rd_done;
    end
    tick();
    wr_valid = 0;
    out_ready = 1;
    chk({tag, "_done"}, 64'(done), 1);
    chk({tag, "_rden_count"}, 64'(n_rden), 64'(c));
    chk({tag, "_words"}, 64'(m_pop), 64'(c));
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 0);
    chk({tag, "_last_count"}, 64'(n_last), 64'(c != 0));
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 64'(rd_busy), 0);
    chk({tag, "_done"}, 64'(rd_done), 0);
    chk({tag, "_out_valid"}, 64'(out_valid), 0);
    chk({tag, "_out_last"}, 64'(out_last), 0);
    chk({tag, "_wr_ready"}, 64'(wr_ready), 0);
    chk({tag, "_rden"}, 64'(ram_rden), 0);
    chk({tag, "_wren"}, 64'(ram_wren), 0);
    chk({tag, "_out_data"}, 64'(out_data), 0);
    chk({tag, "_ram_address"}, 64'(ram_address), 0);
  endtask
  initial begin
    int rb, rc;
    bit found;
    rst_n = 0; rd_start = 0; rd_base = 0; rd_count = 0; out_ready = 1;
    wr_valid = 0; wr_addr = 0; wr_data = 0; ld = 0;
    checks = 0; failures = 0; m_base = 0; m_count = 0; m_iss = 0; m_pop = 0; n_rden = 0; n_last = 0;
    tick(); ld = 1;
    tick(); ld = 0;
    @(negedge clock);
    chk_idle("reset");
    tick(); rst_n = 1;
    tick(); start(0, 8);
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      chk("b8_rden", 64'(ram_rden), 64'(k >= 1 && k <= 8));
      chk("b8_out_valid", 64'(out_valid), 64'(k >= 4 && k <= 11));
      chk("b8_rd_done", 64'(rd_done), 64'(k == 12));
      chk("b8_rd_busy", 64'(rd_busy), 64'(k >= 1 && k <= 12));
      tick();
      rd_start = 0;
    end
    chk("b8_rden_count", 64'(n_rden), 8);
    chk("b8_words", 64'(m_pop), 8);
    chk("b8_last_count", 64'(n_last), 1);
    tick(); start(510, 4);
    finish("wrap", 4, 0);
    tick(); out_ready = 0; start(20, 10);
    tick(); rd_start = 0;
    repeat (20) tick();
    @(negedge clock);
    chk("bp_stalled_rden", 64'(n_rden), 4);
    chk("bp_out_valid", 64'(out_valid), 1);
    chk("bp_no_issue", 64'(ram_rden), 0);
    chk("bp_busy", 64'(rd_busy), 1);
    tick(); out_ready = 1;
    finish("bp", 10, 0);
    tick(); start(0, 0);
    @(negedge clock);
    chk("zero_busy_t0", 64'(rd_busy), 0);
    tick(); rd_start = 0;
    @(negedge clock);
    chk("zero_done_t1", 64'(rd_done), 1);
    chk("zero_busy_t1", 64'(rd_busy), 1);
    tick();
    @(negedge clock);
    chk("zero_done_t2", 64'(rd_done), 0);
    chk("zero_busy_t2", 64'(rd_busy), 0);
    chk("zero_rden", 64'(n_rden), 0);
    chk("zero_words", 64'(m_pop), 0);
    tick(); wr_valid = 1; wr_addr = 300; wr_data = $urandom; start(200, 4);
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      chk("cont_wren", 64'(ram_wren), 64'(k == 0 || k % 2 == 1));
      chk("cont_rden", 64'(ram_rden), 64'(k >= 2 && k % 2 == 0));
      tick();
      rd_start = 0;
      wr_addr = 9'(301 + k);
      wr_data = $urandom;
    end
    wr_valid = 0;
    finish("cont", 4, 0);
    tick(); start(300, 10);
    finish("readback", 10, 0);
    tick(); start(0, 8);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      rd_start = 0;
      @(negedge clock);
      found = m_pop == 3;
    end
    chk("rst_mid_reached", 64'(found), 1);
    #1 rst_n = 0;
    #1 chk_idle("rst_mid");
    tick();
    tick(); rst_n = 1;
    tick(); start(100, 2);
    finish("after_rst", 2, 0);
    for (int b = 0; b < 6; b++) begin
      rb = $urandom_range(0, 511);
      rc = $urandom_range(1, 40);
      tick(); start(rb, rc);
      finish("rand", rc, 1);
    end
    tick(); start(37, 512);
    finish("full", 512, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
